// File: rtl/fas_pkg.sv
// -----------------------------------------------------------------------------
// fas_pkg
// Shared sizing constants and types for the FFT peak scheduler.
//   NBIN : bins per FFT frame (power of two)
//   DW   : width of each signed real / imaginary half
//   IW   : bin index width, log2(NBIN)
//   PW   : width of a bin power re^2 + im^2 (unsigned)
//   FW   : width of one flat frame on the input bus
//   state_t : scheduler FSM states
//   bin_t   : one bin word, real half in the upper DW bits
// -----------------------------------------------------------------------------
package fas_pkg;

    localparam int NBIN = 16;
    localparam int DW   = 16;
    localparam int IW   = 4;
    localparam int PW   = 2 * DW + 1;
    localparam int FW   = NBIN * 2 * DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Packed so that {re, im} lines up with the bin word layout on fft_d.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } bin_t;

endpackage

// File: rtl/fft_peak_scheduler_if.sv
// -----------------------------------------------------------------------------
// fft_peak_scheduler_if
// Frame-in / result-out bundle between the FFT engine, the peak scheduler and
// the frequency-analysis consumer.
//   fft_valid : frame present on fft_d
//   fft_ready : scheduler can accept a frame this cycle
//   fft_d     : flat frame, bin k at [k*2*DW +: 2*DW]
//   done      : one-cycle pulse, freq / peak_pow valid
//   freq      : index of the max-power bin
//   peak_pow  : re^2 + im^2 of that bin
// master = frame producer / result consumer side, slave = the scheduler.
// -----------------------------------------------------------------------------
interface fft_peak_scheduler_if
    import fas_pkg::*;
;
    logic          fft_valid;
    logic          fft_ready;
    logic [FW-1:0] fft_d;
    logic          done;
    logic [IW-1:0] freq;
    logic [PW-1:0] peak_pow;

    modport master (
        output fft_valid,
        output fft_d,
        input  fft_ready,
        input  done,
        input  freq,
        input  peak_pow
    );

    modport slave (
        input  fft_valid,
        input  fft_d,
        output fft_ready,
        output done,
        output freq,
        output peak_pow
    );

endinterface

// File: rtl/fas_pow_mac.sv
// -----------------------------------------------------------------------------
// fas_pow_mac
// The single shared signed squarer plus the accumulate adder used to build
// re^2 + im^2 over two consecutive cycles.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : clear the accumulator (new frame)
//   en       : load the accumulator with sum
//   clr      : 1 = sum is operand^2 alone, 0 = sum is acc + operand^2
//   operand  : signed DW-bit value to square
//   sum      : PW-bit unsigned result (combinational)
// -----------------------------------------------------------------------------
module fas_pow_mac
    import fas_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 en,
    input  logic                 clr,
    input  logic signed [DW-1:0] operand,
    output logic        [PW-1:0] sum
);

    logic signed [2*DW-1:0] sq;
    logic        [2*DW-1:0] acc_q;
    logic        [2*DW-1:0] acc_d;

    // A square is never negative, so the signed 2*DW product can be reused as
    // an unsigned value; (-2^(DW-1))^2 = 2^(2*DW-2) still fits.
    assign sq = operand * operand;

    always_comb begin
        sum = (clr ? {PW{1'b0}} : {1'b0, acc_q}) + {1'b0, $unsigned(sq)};
    end

    // Only a lone square is ever stored, so the low 2*DW bits are exact.
    always_comb begin
        acc_d = acc_q;
        if (flush) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[2*DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fft_peak_scheduler.sv
// -----------------------------------------------------------------------------
// fft_peak_scheduler
// Captures one NBIN-point FFT frame and finds the bin with the largest power
// re^2 + im^2, using one shared squarer stepped over the real then imaginary
// half of every bin (2*NBIN cycles per frame).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; discards any frame in progress
//   bus : fft_peak_scheduler_if.slave
//         fft_valid/fft_ready/fft_d  frame handshake
//         done/freq/peak_pow         result, done pulses for one cycle
// Ties go to the lowest bin index. The DONE cycle can accept the next frame,
// giving one frame per 2*NBIN+1 cycles back to back.
// -----------------------------------------------------------------------------
module fft_peak_scheduler
    import fas_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fft_peak_scheduler_if.slave  bus
);

    state_t        state_q, state_d;
    logic [IW-1:0] bin_q,   bin_d;
    logic          sub_q,   sub_d;     // 0 = real step, 1 = imaginary step
    logic [PW-1:0] max_q,   max_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          done_q,  done_d;
    logic [IW-1:0] freq_q,  freq_d;
    logic [PW-1:0] peak_q,  peak_d;

    bin_t frame_q [NBIN];
    bin_t frame_d [NBIN];

    logic                 ready;
    logic                 accept;
    bin_t                 cur_bin;
    logic signed [DW-1:0] operand;
    logic                 mac_flush;
    logic                 mac_en;
    logic                 mac_clr;
    logic        [PW-1:0] mac_sum;

    // Ready depends on the state register alone so it never combinationally
    // follows fft_valid.
    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign accept = ready && bus.fft_valid;

    // Frame buffer: loaded only on the accept edge, otherwise holds.
    genvar gi;
    generate
        for (gi = 0; gi < NBIN; gi++) begin : g_frame
            assign frame_d[gi] = accept ? bin_t'(bus.fft_d[gi*2*DW +: 2*DW])
                                        : frame_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign cur_bin = frame_q[bin_q];
    assign operand = sub_q ? cur_bin.im : cur_bin.re;

    fas_pow_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .flush   (mac_flush),
        .en      (mac_en),
        .clr     (mac_clr),
        .operand (operand),
        .sum     (mac_sum)
    );

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        sub_d     = sub_q;
        max_d     = max_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        freq_d    = freq_q;
        peak_d    = peak_q;
        mac_flush = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.fft_valid) begin
                    state_d   = CALC;
                    bin_d     = '0;
                    sub_d     = 1'b0;
                    max_d     = '0;
                    idx_d     = '0;
                    mac_flush = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end

            CALC: begin
                if (!sub_q) begin
                    // Real step: park re^2 in the accumulator.
                    mac_en  = 1'b1;
                    mac_clr = 1'b1;
                    sub_d   = 1'b1;
                end else begin
                    // Imaginary step: mac_sum is this bin's full power.
                    sub_d = 1'b0;
                    if ((bin_q == '0) || (mac_sum > max_q)) begin
                        max_d = mac_sum;
                        idx_d = bin_q;
                    end
                    if (bin_q == IW'(NBIN - 1)) begin
                        // Publish the final tracker values together with the
                        // move to DONE so done lines up with the DONE state.
                        state_d = DONE;
                        done_d  = 1'b1;
                        freq_d  = idx_d;
                        peak_d  = max_d;
                    end else begin
                        bin_d = bin_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            sub_q   <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            freq_q  <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            sub_q   <= sub_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            peak_q  <= peak_d;
        end
    end

    assign bus.fft_ready = ready;
    assign bus.done      = done_q;
    assign bus.freq      = freq_q;
    assign bus.peak_pow  = peak_q;

endmodule

// File: tb/tb_fft_peak_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_scheduler
// Directed vector table plus hand-written sequences for the peak scheduler.
// -----------------------------------------------------------------------------
module tb_fft_peak_scheduler;
    import fas_pkg::*;

    typedef logic [FW-1:0] frame_t;

    typedef struct {
        string  name;
        frame_t frame;
        int     exp_freq;
        longint exp_pow;
    } vec_t;

    typedef struct {
        int     fr;
        longint pw;
        int     c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fft_peak_scheduler_if bus ();

    fft_peak_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t put_bin(input frame_t f, input int k, input int re, input int im);
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        frame_t        g;
        r = re[DW-1:0];
        i = im[DW-1:0];
        g = f;
        g[k*2*DW +: 2*DW] = {r, i};
        return g;
    endfunction

    // Reference: power = re^2 + im^2, first maximum wins.
    task automatic model(input frame_t f, output int fr, output longint pw);
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        longint               p;
        fr = 0;
        pw = 0;
        for (int k = 0; k < NBIN; k++) begin
            r = f[k*2*DW + DW +: DW];
            i = f[k*2*DW +: DW];
            p = longint'(r) * longint'(r) + longint'(i) * longint'(i);
            if (k == 0 || p > pw) begin
                pw = p;
                fr = k;
            end
        end
    endtask

    function automatic int rnd_val(input int mode);
        case (mode)
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return int'($urandom_range(0, 6)) - 3;
            default: return ($urandom_range(0, 1) == 1) ? -32768 : 32767;
        endcase
    endfunction

    // Called at a negedge with fft_valid low. Returns the result, the number
    // of cycles from the accept cycle to the done cycle, and done one cycle later.
    task automatic run_frame(input frame_t f, output int fr, output longint pw,
                             output int lat, output logic done_after);
        int guard;
        guard = 0;
        while (!bus.fft_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.fft_ready) begin
            check("ready_wait_timeout", 64'd0, 64'd1);
        end
        bus.fft_valid = 1'b1;
        bus.fft_d     = f;
        @(posedge clk);
        @(negedge clk);
        bus.fft_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        fr = int'(bus.freq);
        pw = longint'(bus.peak_pow);
        @(negedge clk);
        done_after = bus.done;
    endtask

    vec_t   vecs [8];
    frame_t f;
    int     fr;
    longint pw;
    int     lat;
    logic   done_after;
    int     m_fr;
    longint m_pw;
    exp_t   q [$];
    exp_t   e;
    int     last_acc;
    int     last_done;
    int     n_dones;
    logic   exp_ready;

    initial begin
        bus.fft_valid = 1'b0;
        bus.fft_d     = '0;

        // ---------------- vector table ----------------
        f = '0; f = put_bin(f, 5, 300, -400);
        vecs[0] = '{"tone5", f, 5, 64'd250000};

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, k, 1);
        f = put_bin(f, 3, -32768, -32768);
        f = put_bin(f, 12, -32768, -32768);
        vecs[1] = '{"tie_maxneg", f, 3, 64'd2147483648};

        vecs[2] = '{"all_zero", '0, 0, 64'd0};

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, 1, 1);
        f = put_bin(f, 9, -32768, 0);
        vecs[3] = '{"maxneg_re", f, 9, 64'd1073741824};

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, 10, 10);
        f = put_bin(f, 15, 0, 1000);
        vecs[4] = '{"last_bin", f, 15, 64'd1000000};

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, 5, -5);
        vecs[5] = '{"all_tie", f, 0, 64'd50};

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, -7, 3);
        f = put_bin(f, 0, 32767, 32767);
        vecs[6] = '{"bin0_max", f, 0, 64'd2147352578};

        f = '0;
        f = put_bin(f, 2, 0, -20000);
        f = put_bin(f, 6, 19999, 0);
        vecs[7] = '{"im_vs_re", f, 2, 64'd400000000};

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", longint'(bus.fft_ready), 64'd1);
        check("reset_done", longint'(bus.done), 64'd0);
        check("reset_freq", longint'(bus.freq), 64'd0);
        check("reset_peak", longint'(bus.peak_pow), 64'd0);
        $display("reset: ready=%0d done=%0d freq=%0d peak=%0d",
                 bus.fft_ready, bus.done, bus.freq, bus.peak_pow);

        // ---------------- directed table ----------------
        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].frame, fr, pw, lat, done_after);
            $display("vec %s: freq=%0d pow=%0d latency=%0d", vecs[v].name, fr, pw, lat);
            check({vecs[v].name, "_latency"}, longint'(lat), 64'd33);
            check({vecs[v].name, "_freq"}, longint'(fr), longint'(vecs[v].exp_freq));
            check({vecs[v].name, "_pow"}, pw, vecs[v].exp_pow);
            check({vecs[v].name, "_done_pulse"}, longint'(done_after), 64'd0);
        end

        // ---------------- back-to-back, new frame every cycle ----------------
        last_acc  = -1;
        last_done = -1;
        n_dones   = 0;
        for (int c = 0; c < 175; c++) begin
            if (bus.done) begin
                n_dones++;
                if (q.size() == 0) begin
                    check("b2b_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    $display("b2b done %0d: freq=%0d pow=%0d cycle=%0d", n_dones,
                             bus.freq, bus.peak_pow, c);
                    check("b2b_freq", longint'(bus.freq), longint'(e.fr));
                    check("b2b_pow", longint'(bus.peak_pow), e.pw);
                    check("b2b_latency", longint'(c - e.c), 64'd33);
                end
                if (last_done >= 0) check("b2b_spacing", longint'(c - last_done), 64'd33);
                last_done = c;
            end
            exp_ready = (last_acc < 0) || (c - last_acc >= 33);
            check("b2b_ready", longint'(bus.fft_ready), longint'(exp_ready));
            f = '0;
            for (int k = 0; k < NBIN; k++) f = put_bin(f, k, rnd_val(0), rnd_val(0));
            bus.fft_valid = (c < 132);
            bus.fft_d     = f;
            if (bus.fft_valid && exp_ready) begin
                model(f, m_fr, m_pw);
                q.push_back('{m_fr, m_pw, c});
                last_acc = c;
            end
            @(negedge clk);
        end
        bus.fft_valid = 1'b0;
        check("b2b_drained", longint'(q.size()), 64'd0);
        check("b2b_dones", longint'(n_dones), 64'd4);

        // ---------------- reset mid-calculation ----------------
        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, 100, 100);
        f = put_bin(f, 4, 9000, 9000);
        bus.fft_valid = 1'b1;
        bus.fft_d     = f;
        @(posedge clk);
        @(negedge clk);
        bus.fft_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midcalc_busy", longint'(bus.fft_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", longint'(bus.fft_ready), 64'd1);
        check("midrst_done", longint'(bus.done), 64'd0);
        check("midrst_freq", longint'(bus.freq), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) n_dones++;
            @(negedge clk);
        end
        check("midrst_no_done", longint'(n_dones), 64'd0);
        check("midrst_idle", longint'(bus.fft_ready), 64'd1);
        $display("reset mid-frame: dones after reset=%0d ready=%0d", n_dones, bus.fft_ready);

        f = '0;
        for (int k = 0; k < NBIN; k++) f = put_bin(f, k, k * 10, -k);
        f = put_bin(f, 15, -2000, 2000);
        run_frame(f, fr, pw, lat, done_after);
        $display("post-reset frame: freq=%0d pow=%0d latency=%0d", fr, pw, lat);
        check("postrst_freq", longint'(fr), 64'd15);
        check("postrst_pow", pw, 64'd8000000);
        check("postrst_latency", longint'(lat), 64'd33);

        // ---------------- random frames ----------------
        for (int n = 0; n < 1000; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            f = '0;
            for (int k = 0; k < NBIN; k++) f = put_bin(f, k, rnd_val(mode), rnd_val(mode));
            model(f, m_fr, m_pw);
            run_frame(f, fr, pw, lat, done_after);
            $display("rand %0d mode %0d: freq=%0d/%0d pow=%0d/%0d", n, mode, fr, m_fr, pw, m_pw);
            check("rand_freq", longint'(fr), longint'(m_fr));
            check("rand_pow", pw, m_pw);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
